// File: rtl/rs_age_issue.sv
// Age-ordered ALU reservation station with CDB wakeup and a registered issue port.
// Ports: dispatch (disp_*), result snoop (cdb_*), issue (iss_*), occupancy, rdy/flush/rst.
module rs_age_issue #(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3,
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [2:0]               disp_op,
  input  logic [6:0]               disp_type,
  input  logic                     disp_op_other,
  input  logic [31:0]              disp_v1,
  input  logic [31:0]              disp_v2,
  input  logic                     disp_dep1,
  input  logic                     disp_dep2,
  input  logic [ROB_W-1:0]         disp_q1,
  input  logic [ROB_W-1:0]         disp_q2,
  input  logic [ROB_W-1:0]         disp_rob_id,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [2:0]               iss_op,
  output logic [6:0]               iss_type,
  output logic                     iss_op_other,
  output logic [31:0]              iss_v1,
  output logic [31:0]              iss_v2,
  output logic [ROB_W-1:0]         iss_rob_id,
  output logic [DEPTH_W:0]         occupancy
);

  typedef struct packed {
    logic [2:0]       op;
    logic [6:0]       typ;
    logic             other;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic [ROB_W-1:0] rob;
  } ent_t;

  ent_t             ent   [DEPTH];
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] busy, dep1, dep2;
  logic [DEPTH-1:0] ready, sel;
  logic [32:0]      wk1 [DEPTH];
  logic [32:0]      wk2 [DEPTH];
  logic [32:0]      byp1, byp2;
  logic [DEPTH_W-1:0] sel_idx, free_idx;
  logic             accept, load;

  // {hit, value}; iterating downward lets the lowest bus win.
  function automatic logic [32:0] snoop(input logic [ROB_W-1:0] id);
    logic [32:0] r;
    r = '0;
    for (int k = NUM_CDB-1; k >= 0; k--)
      if (cdb_valid[k] && cdb_rob_id[k*ROB_W +: ROB_W] == id)
        r = {1'b1, cdb_value[k*32 +: 32]};
    return r;
  endfunction

  always_comb begin
    ready = busy & ~dep1 & ~dep2;
    sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin : pick
      logic blk;
      blk = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        blk = blk | (ready[j] & older[j][i]);
      sel[i] = ready[i] & ~blk;
    end
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel[i]) sel_idx = DEPTH_W'(i);
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!busy[i]) free_idx = DEPTH_W'(i);
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = snoop(ent[i].q1);
      wk2[i] = snoop(ent[i].q2);
    end
    byp1 = snoop(disp_q1);
    byp2 = snoop(disp_q2);
  end

  assign disp_ready = occupancy != (DEPTH_W+1)'(DEPTH);
  assign accept = rdy & ~flush & disp_valid & disp_ready;
  assign load   = rdy & ~flush & (|ready)
                & (~iss_valid | iss_ready);

  always_ff @(posedge clk) begin
    if (!rst || (rdy && flush)) begin
      busy         <= '0;
      dep1         <= '0;
      dep2         <= '0;
      occupancy    <= '0;
      iss_valid    <= 1'b0;
      iss_op       <= '0;
      iss_type     <= '0;
      iss_op_other <= 1'b0;
      iss_v1       <= '0;
      iss_v2       <= '0;
      iss_rob_id   <= '0;
      for (int i = 0; i < DEPTH; i++)
        older[i] <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && dep1[i] && wk1[i][32]) begin
          dep1[i]   <= 1'b0;
          ent[i].v1 <= wk1[i][31:0];
        end
        if (busy[i] && dep2[i] && wk2[i][32]) begin
          dep2[i]   <= 1'b0;
          ent[i].v2 <= wk2[i][31:0];
        end
      end
      if (load) begin
        busy[sel_idx] <= 1'b0;
        iss_valid     <= 1'b1;
        iss_op        <= ent[sel_idx].op;
        iss_type      <= ent[sel_idx].typ;
        iss_op_other  <= ent[sel_idx].other;
        iss_v1        <= ent[sel_idx].v1;
        iss_v2        <= ent[sel_idx].v2;
        iss_rob_id    <= ent[sel_idx].rob;
      end else if (iss_valid && iss_ready) begin
        iss_valid <= 1'b0;
      end
      if (accept) begin
        busy[free_idx] <= 1'b1;
        dep1[free_idx] <= disp_dep1 & ~byp1[32];
        dep2[free_idx] <= disp_dep2 & ~byp2[32];
        ent[free_idx] <= '{
          op:    disp_op,
          typ:   disp_type,
          other: disp_op_other,
          v1:    (disp_dep1 && byp1[32]) ? byp1[31:0] : disp_v1,
          v2:    (disp_dep2 && byp2[32]) ? byp2[31:0] : disp_v2,
          q1:    disp_q1,
          q2:    disp_q2,
          rob:   disp_rob_id
        };
        for (int i = 0; i < DEPTH; i++)
          older[i][free_idx] <= busy[i];
        older[free_idx] <= '0;
      end
      occupancy <= occupancy
                 + (DEPTH_W+1)'(accept)
                 - (DEPTH_W+1)'(load);
    end
  end

endmodule
